led_fade_pwm: RTL and testbench

//   Sits downstream of the LED pattern rotator. Consumes its 3-bit active-low

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_fade_channel.sv | 99 +++++++++
 rtl/led_fade_pwm.sv | 59 +++++
 tb/tb_led_fade_pwm.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED fade/PWM block.
// Gamma correction is selected at build time with LED_GAMMA_EN.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE_OFF  = 2'd0,
        RAMP_UP   = 2'd1,
        IDLE_ON   = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_t;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;
    localparam int   NUM_CH  = 3;

    function automatic logic is_ramping(input fade_state_t s);
        return (s == RAMP_UP) || (s == RAMP_DOWN);
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade FSM, brightness level, optional gamma stage
// (LED_GAMMA_EN) and the PWM compare driving the active-low pin.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                step_tick,
    input  logic                led_in,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_pwm_out,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    fade_state_t         state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                out_q, out_d;
    logic [PWM_BITS-1:0] level_inc, level_dec, eff_level;
    logic                target_on, lit;

    assign target_on = (led_in == LED_ON);
    assign level_inc = (level_q == MAX) ? MAX : level_q + 1'b1;
    assign level_dec = (level_q == '0) ? '0 : level_q - 1'b1;

    // A reversal only flips direction; the level moves on the next tick.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            IDLE_OFF: if (target_on) state_d = RAMP_UP;
            RAMP_UP: begin
                if (!target_on) begin
                    state_d = RAMP_DOWN;
                end else if (step_tick) begin
                    level_d = level_inc;
                    if (level_inc == MAX) state_d = IDLE_ON;
                end
            end
            IDLE_ON: if (!target_on) state_d = RAMP_DOWN;
            RAMP_DOWN: begin
                if (target_on) begin
                    state_d = RAMP_UP;
                end else if (step_tick) begin
                    level_d = level_dec;
                    if (level_dec == '0) state_d = IDLE_OFF;
                end
            end
            default: state_d = IDLE_OFF;
        endcase
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    logic [PWM_BITS-1:0]   eff_q, eff_d;

    assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};

    // Full brightness must stay fully on; the square alone would land one short.
    always_comb begin
        eff_d = level_sq[2*PWM_BITS-1:PWM_BITS];
        if (level_q == MAX) eff_d = MAX;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) eff_q <= '0;
        else        eff_q <= eff_d;
    end

    assign eff_level = eff_q;
`else
    assign eff_level = level_q;
`endif

    assign lit = (eff_level == MAX) || (eff_level > pwm_cnt);

    always_comb begin
        out_d = lit ? LED_ON : LED_OFF;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= IDLE_OFF;
            level_q <= '0;
            out_q   <= LED_OFF;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            out_q   <= out_d;
        end
    end

    assign led_pwm_out = out_q;
    assign ramping     = is_ramping(state_d);

endmodule

// File: rtl/led_fade_pwm.sv
// RGB LED fader: turns pattern edges into linear PWM brightness ramps.
// Define LED_GAMMA_EN for a squared brightness curve (one extra cycle to pin).
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 93_750
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [2:0] led_in,
    output logic [2:0] led_pwm_out,
    output logic       busy
);

    localparam int               PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic                busy_q, busy_d;
    logic                step_tick;
    logic [NUM_CH-1:0]   ramping;

    assign step_tick = (presc_q == PRE_LAST);

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        presc_d   = step_tick ? '0 : presc_q + 1'b1;
        busy_d    = |ramping;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .step_tick   (step_tick),
            .led_in      (led_in[i]),
            .pwm_cnt     (pwm_cnt_q),
            .led_pwm_out (led_pwm_out[i]),
            .ramping     (ramping[i])
        );
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench: fast-stepping instance for ramp/reversal/reset timing,
// slow-stepping instance for PWM duty at held brightness levels.
module tb_led_fade_pwm;

    logic       clk_in = 1'b0;
    logic       rst_n, rstb_n;
    logic [2:0] led_in, ledb_in, out_a, out_b;
    logic       busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;
    int base, r, bad, n;

`ifdef LED_GAMMA_EN
    localparam int EXP_L4 = 1;
    localparam int EXP_L8 = 4;
`else
    localparam int EXP_L4 = 4;
    localparam int EXP_L8 = 8;
`endif

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) ecount <= ecount + 1;

    led_fade_pwm #(.PWM_BITS(4), .STEP_DIV(2)) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .led_in(led_in),
        .led_pwm_out(out_a), .busy(busy_a)
    );

    led_fade_pwm #(.PWM_BITS(4), .STEP_DIV(64)) dut_b (
        .clk_in(clk_in), .rst_n(rstb_n), .led_in(ledb_in),
        .led_pwm_out(out_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Wait until the negedge following posedge number n.
    task automatic goto(input int n);
        while (ecount < n) @(negedge clk_in);
    endtask

    task automatic count_b_on(output int cnt);
        cnt = 0;
        repeat (16) begin
            if (out_b[0] == 1'b0) cnt++;
            @(negedge clk_in);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rstb_n = 1'b0;
        led_in = 3'b000; ledb_in = 3'b000;
        repeat (3) @(negedge clk_in);
        chk("rst_out_a",  out_a,  3'b111);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_out_b",  out_b,  3'b111);
        chk("rst_busy_b", busy_b, 1'b0);

        // Ramp ch0 up from zero.
        rst_n = 1'b1; rstb_n = 1'b1;
        led_in = 3'b110; ledb_in = 3'b110;
        base = ecount;
        goto(base + 1);
        chk("up_busy_start", busy_a, 1'b1);
        goto(base + 29);
        chk("up_busy_late", busy_a, 1'b1);
        chk("up_ch12_off", out_a[2:1], 2'b11);
        goto(base + 30);
        chk("up_done", busy_a, 1'b0);
        goto(base + 33);
        bad = 0;
        repeat (16) begin
            if (out_a !== 3'b110) bad++;
            @(negedge clk_in);
        end
        chk("full_on_const", bad, 0);

        // Full ramp down from MAX.
        goto(base + 49);
        led_in = 3'b111;
        goto(base + 79);
        chk("down_busy_late", busy_a, 1'b1);
        goto(base + 80);
        chk("down_done", busy_a, 1'b0);

        // Reverse mid-ramp at level 5.
        goto(base + 81);
        led_in = 3'b110;
        goto(base + 92);
        chk("rev_busy_up", busy_a, 1'b1);
        led_in = 3'b111;
        goto(base + 101);
        chk("rev_busy_late", busy_a, 1'b1);
        goto(base + 102);
        chk("rev_done", busy_a, 1'b0);

        // Single-cycle reset with ch0 at level 10.
        led_in = 3'b110;
        goto(base + 122);
        rst_n = 1'b0;
        goto(base + 123);
        chk("mid_rst_out", out_a, 3'b111);
        chk("mid_rst_busy", busy_a, 1'b0);
        rst_n = 1'b1;
        led_in = 3'b111;
        r = ecount;
        bad = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (out_a !== 3'b111 || busy_a !== 1'b0) bad++;
        end
        chk("post_rst_dark", bad, 0);
        led_in = 3'b110;
        goto(r + 49);
        chk("post_rst_busy", busy_a, 1'b1);
        goto(r + 50);
        chk("post_rst_full", busy_a, 1'b0);

        // Slow instance: duty at held levels 4 and 8.
        goto(base + 264);
        count_b_on(n);
        chk("duty_l4", n, EXP_L4);
        goto(base + 520);
        chk("b_busy_mid", busy_b, 1'b1);
        chk("b_ch12_off", out_b[2:1], 2'b11);
        count_b_on(n);
        chk("duty_l8", n, EXP_L8);
        goto(base + 959);
        chk("b_busy_late", busy_b, 1'b1);
        goto(base + 960);
        chk("b_done", busy_b, 1'b0);
        goto(base + 963);
        chk("b_full_on", out_b, 3'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
